// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared definitions for the UART receive front end: the receiver
//           state encoding, the data width and the baud divisor function.
// Ports   : none (package)
// Config  : UART_RX_PARITY_EN selects 8E1 framing in uart_rx_fifo; the
//           ST_PARITY encoding is always present so the enum is stable.
// Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   // Clock cycles per bit period (integer division, truncating).
   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module  : byte_fifo
// Purpose : Small first-word-fall-through byte buffer. The head entry is
//           shown combinationally on rd_data; a push into a full FIFO with
//           no concurrent pop is dropped and flagged with a one-cycle ovf.
// Ports   : clk, rst (async, active-high)
//           wr_en / wr_data          - push side
//           rd_data / rd_vld / rd_rdy - FWFT pop side
//           ovf                      - dropped-push pulse (registered)
// Params  : DEPTH - power of two, >= 2
// Rev     : 1.0  initial release
// ============================================================================
module byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_rdy,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_vld,
   output logic              ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic full;
   logic pop;
   logic wr_ok;

   assign rd_vld  = (count != '0);
   assign full    = (count == FULL_CNT);
   assign pop     = rd_vld && rd_rdy;
   // When full, a simultaneous pop frees the head slot in the same edge;
   // since wr_ptr == rd_ptr then, the new byte lands where the popped one was.
   assign wr_ok   = wr_en && (!full || pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         ovf <= wr_en && full && !pop;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Purpose : UART receive front end. Synchronises rxd, decodes frames by
//           mid-bit sampling and buffers good bytes in a FWFT byte_fifo
//           presented over a valid/ready handshake.
// Ports   : clk, rst (async, active-high)
//           rxd       - raw serial line, idle high, asynchronous
//           dout      - byte at FIFO head
//           dout_vld  - FIFO not empty
//           dout_rdy  - consumer accepts dout this cycle
//           frame_err - one-cycle pulse: bad stop bit (or bad parity)
//           ovf       - one-cycle pulse: good byte dropped, FIFO full
//           busy      - receiver not idle
// Params  : CLK_FREQ (Hz), BAUD, FIFO_DEPTH (power of two, >= 2)
// Config  : define UART_RX_PARITY_EN for 8E1 framing; default is 8N1.
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rxd,
   output logic [DATA_W-1:0] dout,
   output logic              dout_vld,
   input  logic              dout_rdy,
   output logic              frame_err,
   output logic              ovf,
   output logic              busy
);

   localparam int DIV   = calc_div(CLK_FREQ, BAUD);
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   // The counter is loaded with N-1 and the sample taken when it reads zero,
   // so a load at start detection lands the sample exactly N cycles later.
   localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV - 1);

   // ---------------------------------------------------------------- sync
   logic sync1;
   logic rxs;
   logic rxs_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
         rxs_d <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
         rxs_d <= rxs;
      end
   end

   // ---------------------------------------------------------------- FSM
   rx_state_t         state;
   rx_state_t         state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [2:0]        bit_idx;
   logic [2:0]        bit_nxt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt;
   logic              frame_err_nxt;
   logic              push;
   logic              tick;
   logic              stop_ok;

`ifdef UART_RX_PARITY_EN
   logic par_bad;
   logic par_bad_nxt;

   // Even parity: the nine bits (data + parity) must hold an even count of ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_bad <= 1'b0;
      end else begin
         par_bad <= par_bad_nxt;
      end
   end

   assign stop_ok = rxs && !par_bad;
`else
   assign stop_ok = rxs;
`endif

   assign tick = (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bit_idx   <= bit_nxt;
         shreg     <= shreg_nxt;
         frame_err <= frame_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      bit_nxt       = bit_idx;
      shreg_nxt     = shreg;
      frame_err_nxt = 1'b0;
      push          = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_nxt   = par_bad;
`endif
      case (state)
         ST_IDLE: begin
            // rxs_d must be high, so a held-low break cannot retrigger.
            if (rxs_d && !rxs) begin
               state_nxt = ST_START;
               cnt_nxt   = HALF_LD;
            end
         end
         ST_START: begin
            if (tick) begin
               if (!rxs) begin
                  state_nxt = ST_DATA;
                  cnt_nxt   = DIV_LD;
                  bit_nxt   = 3'd0;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shreg_nxt = {rxs, shreg[DATA_W-1:1]};
               cnt_nxt   = DIV_LD;
               bit_nxt   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               par_bad_nxt = ^{shreg, rxs};
               cnt_nxt     = DIV_LD;
               state_nxt   = ST_STOP;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               state_nxt = ST_IDLE;
               if (stop_ok) begin
                  push = 1'b1;
               end else begin
                  frame_err_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy = (state != ST_IDLE);

   // ---------------------------------------------------------------- FIFO
   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (shreg),
      .rd_rdy  (dout_rdy),
      .rd_data (dout),
      .rd_vld  (dout_vld),
      .ovf     (ovf)
   );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_fifo
// Purpose : Self-checking bench for uart_rx_fifo (CLK_FREQ=1 MHz, BAUD=100k,
//           DIV=10). Directed scenarios plus randomized frames checked against
//           a queue model of delivered bytes, frame errors and overflows.
// Config  : define UART_RX_PARITY_EN to build and check the 8E1 variant.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

   localparam int CLK_FREQ   = 1_000_000;
   localparam int BAUD       = 100_000;
   localparam int FIFO_DEPTH = 4;
   localparam int DIV        = CLK_FREQ / BAUD;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic [7:0] dout;
   logic       dout_vld;
   logic       dout_rdy;
   logic       frame_err;
   logic       ovf;
   logic       busy;

   uart_rx_fifo #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .dout      (dout),
      .dout_vld  (dout_vld),
      .dout_rdy  (dout_rdy),
      .frame_err (frame_err),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- monitor
   logic [7:0] got[$];
   int         ferr_cnt  = 0;
   int         ovf_cnt   = 0;
   int         vld_cyc   = 0;
   int         last_rise = 0;
   logic       vld_prev  = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) ferr_cnt++;
         if (ovf) ovf_cnt++;
         if (dout_vld) begin
            vld_cyc++;
            if (!vld_prev) last_rise = cyc;
         end
         if (dout_vld && dout_rdy) got.push_back(dout);
         vld_prev = dout_vld;
      end else begin
         vld_prev = 1'b0;
      end
   end

   // ---------------------------------------------------------------- model
   // exp_q: bytes the consumer should eventually see, in order.
   // held : bytes currently buffered, as implied by the FIFO rules.
   logic [7:0] exp_q[$];
   int         held     = 0;
   int         exp_ferr = 0;
   int         exp_ovf  = 0;

   task automatic model_frame(input logic [7:0] b, input bit stop_ok,
                              input bit rdy_on, input bit pop_on_push);
      if (rdy_on) held = 0;
      if (!stop_ok) begin
         exp_ferr++;
      end else begin
         if (pop_on_push && held > 0) held--;
         if (held < FIFO_DEPTH) begin
            exp_q.push_back(b);
            held++;
         end else begin
            exp_ovf++;
         end
      end
      if (rdy_on) held = 0;
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_queues(input string tag);
      int n;
      check_val({tag, "_count"}, got.size(), exp_q.size());
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check_val($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
      end
      check_val({tag, "_ferr"}, ferr_cnt, exp_ferr);
      check_val({tag, "_ovf"}, ovf_cnt, exp_ovf);
      got.delete();
      exp_q.delete();
   endtask

   // ---------------------------------------------------------------- driver
   int t_fall    = 0;
   bit par_flip  = 1'b0;

   task automatic bit_out(input logic v);
      rxd = v;
      repeat (DIV) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      @(posedge clk);
      #1;
      t_fall = cyc;
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
      bit_out((^b) ^ par_flip);
`endif
      bit_out(stop_v);
      rxd = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int vld_base;
      logic [7:0] rb;
      bit rs;
      bit rr;

      rst      = 1'b1;
      rxd      = 1'b1;
      dout_rdy = 1'b0;
      idle(3);
      check_val("reset_outputs", {dout, dout_vld, frame_err, ovf, busy}, 32'h0);
      rst = 1'b0;
      idle(5);

      // Single frame, latency from rxd fall = 2 sync + 96.
      dout_rdy = 1'b1;
      vld_base = vld_cyc;
      send_frame(8'hA5, 1'b1);
      model_frame(8'hA5, 1'b1, 1'b1, 1'b0);
      idle(30);
      check_val("single_latency", last_rise - t_fall, 98);
      check_val("single_vld_width", vld_cyc - vld_base, 1);
      compare_queues("single");

      // Glitch: 3 cycles low is rejected at the start-bit check.
      @(posedge clk); #1;
      rxd = 1'b0;
      repeat (3) @(posedge clk);
      #1 rxd = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_val("glitch_busy_rise", busy, 1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_val("glitch_busy_fall", busy, 0);
      idle(20);
      compare_queues("glitch");

      // Framing error: stop bit low, then idle high.
      send_frame(8'h3C, 1'b0);
      model_frame(8'h3C, 1'b0, 1'b1, 1'b0);
      idle(30);
      check_val("ferr_empty", dout_vld, 0);
      compare_queues("ferr");

      // Overflow: five bytes into a four-deep FIFO with no consumer.
      dout_rdy = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         send_frame(8'(k), 1'b1);
         model_frame(8'(k), 1'b1, 1'b0, 1'b0);
      end
      idle(30);
      check_val("ovf_head", {dout_vld, dout}, {1'b1, 8'h01});
      dout_rdy = 1'b1;
      idle(10);
      held = 0;
      compare_queues("ovf");

      // Full FIFO with a pop on the exact push cycle of the fifth byte.
      dout_rdy = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         send_frame(8'(k), 1'b1);
         model_frame(8'(k), 1'b1, 1'b0, 1'b0);
      end
      idle(20);
      fork
         send_frame(8'h05, 1'b1);
         begin
            repeat (98) @(posedge clk);
            #1 dout_rdy = 1'b1;
            @(posedge clk);
            #1 dout_rdy = 1'b0;
         end
      join
      model_frame(8'h05, 1'b1, 1'b0, 1'b1);
      idle(20);
      dout_rdy = 1'b1;
      idle(10);
      held = 0;
      compare_queues("fullpop");

      // Reset mid-frame, with a byte already buffered.
      dout_rdy = 1'b0;
      send_frame(8'h33, 1'b1);
      model_frame(8'h33, 1'b1, 1'b0, 1'b0);
      idle(10);
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (56) @(posedge clk);
            @(negedge clk);
            check_val("rst_busy_before", busy, 1);
            rst = 1'b1;
            #1;
            check_val("rst_outputs", {dout, dout_vld, frame_err, ovf, busy}, 32'h0);
            exp_q.delete();
            got.delete();
            held = 0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      idle(20);
      dout_rdy = 1'b1;
      send_frame(8'h5A, 1'b1);
      model_frame(8'h5A, 1'b1, 1'b1, 1'b0);
      idle(30);
      compare_queues("rst");

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 needs parity bit 1.
      par_flip = 1'b0;
      send_frame(8'h07, 1'b1);
      model_frame(8'h07, 1'b1, 1'b1, 1'b0);
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      model_frame(8'h07, 1'b0, 1'b1, 1'b0);
      par_flip = 1'b0;
      idle(30);
      compare_queues("parity");
`endif

      // Randomized frames, stop bits, consumer readiness and gaps.
      for (int k = 0; k < 14; k++) begin
         rb = 8'($urandom);
         rs = ($urandom_range(0, 5) != 0);
         rr = ($urandom_range(0, 2) != 0);
         dout_rdy = rr;
         send_frame(rb, rs);
         model_frame(rb, rs, rr, 1'b0);
         if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 15));
      end
      idle(20);
      dout_rdy = 1'b1;
      idle(10);
      held = 0;
      compare_queues("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the serial debug unit. It synchronises the host `rxd` line, decodes 8N1 UART frames by mid-bit sampling and buffers the received bytes in a small FIFO. Bytes are presented to the SDU command parser over a valid/ready handshake. The block sits directly upstream of the SDU command decoder, and one instance replaces the SDU's raw `rxd` input.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: system clock in Hz.
- `BAUD`, default 9600: line rate in baud.
- `FIFO_DEPTH`, default 4: byte buffer depth; must be a power of two, at least 2.

Ports:
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: reset, asynchronous, active-high.
- `rxd` input 1: raw serial line, asynchronous to `clk`, idle high.
- `dout` output 8: byte at the FIFO head.
- `dout_vld` output 1: FIFO not empty; `dout` is valid.
- `dout_rdy` input 1: consumer accepts `dout` on this cycle.
- `frame_err` output 1: one-cycle pulse; stop bit sampled low.
- `ovf` output 1: one-cycle pulse; a good byte arrived while the FIFO was full and no pop occurred.
- `busy` output 1: receiver is not IDLE.

## Operation
- `DIV = CLK_FREQ/BAUD` (integer division) and `HALF = DIV/2` are localparams. The bit counter width is `$clog2(DIV)`.
- `rxd` passes through a 2-FF synchroniser whose flops reset to 1, giving `rxs`. A third flop holds `rxs_d` for edge detection.
- The FSM has states IDLE, START, DATA, STOP, plus PARITY when enabled.
  - IDLE: when `rxs_d=1` and `rxs=0`, load the counter and go to START.
  - START: wait `HALF` cycles, then sample. If `rxs=0`, go to DATA with bit index 0. If `rxs=1`, treat it as a glitch and return to IDLE with no pulse.
  - DATA: every `DIV` cycles, sample `rxs` into the shift register, LSB first. After bit 7, go to STOP, or to PARITY when enabled.
  - STOP: after `DIV` cycles, sample.
    - If `rxs=1`, push the byte into the FIFO.
    - If `rxs=0`, pulse `frame_err` and discard the byte.
    - In either case, return to IDLE.
  - In IDLE, a falling edge can only occur once the line has returned high, so a break condition produces exactly one `frame_err`.
- FIFO behaviour:
  - The FIFO is first-word-fall-through, so `dout` shows the head entry combinationally from the storage array.
  - A pop occurs when `dout_vld && dout_rdy`.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full. In that case the count is unchanged and no `ovf` is raised.
  - A push when full with no pop drops the new byte and pulses `ovf`. FIFO contents are unchanged.
  - Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. The count is one bit wider.
  - `dout_rdy` while empty has no effect.
- Reset:
  - Reset values: FSM IDLE, FIFO empty, `dout_vld=0`, `frame_err=0`, `ovf=0`, `busy=0`, synchroniser flops at 1.
  - `dout` resets to 0: the storage array resets to 0.
  - Reset mid-frame discards the partial byte. The next frame is decoded normally.

## Timing
- Synchroniser latency is 2 cycles from the `rxd` edge to the `rxs` edge.
- Start is detected on the cycle `rxs` first reads 0.
- Sample points, counted from start detection:
  - Start-bit check at +`HALF`.
  - Data bit *n* at +`HALF`+(n+1)·`DIV`.
  - Stop bit at +`HALF`+9·`DIV`, or +`HALF`+10·`DIV` with parity.
- The push is registered, so `dout_vld` rises 1 cycle after the stop sample.
- `frame_err` and `ovf` are asserted on the cycle after the stop sample, for exactly one cycle.
- `busy` is high from the cycle after start detection through the stop-sample cycle.
- Back-to-back frames are supported because IDLE is re-entered immediately after the stop sample.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state follows DATA and samples one bit after `DIV` cycles.
  - Even parity is checked over the 8 data bits plus the parity bit; a mismatch marks the byte bad.
  - A bad byte is discarded at STOP and `frame_err` pulses.
  - The frame is 8E1.
- `UART_RX_PARITY_EN` undefined: no PARITY state, 8N1 frames, no parity logic.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum;
  - the 8-bit data width constant;
  - a constant function computing `DIV` from `CLK_FREQ` and `BAUD`.
- The sub-module `byte_fifo` (parameter `DEPTH`) holds storage, pointers, count, `ovf` detection and FWFT output.
- The top level holds the synchroniser, counter, FSM and shift register.

## Test plan
Bench parameters: `CLK_FREQ=1_000_000`, `BAUD=100_000`, giving `DIV=10` and `HALF=5`.
- Single frame: send 0xA5 with `dout_rdy=1`.
  - `dout_vld` pulses for 1 cycle with `dout=0xA5`.
  - The pulse occurs 96 cycles after start detection.
  - `frame_err=0` and `ovf=0`.
- Glitch: drive `rxd` low for 3 cycles, then high.
  - No byte is pushed and no `frame_err`.
  - `busy` falls within 6 cycles.
- Framing error: send 0x3C with the stop bit low, then idle high.
  - One `frame_err` pulse.
  - FIFO stays empty.
- Overflow: hold `dout_rdy=0` and send 0x01..0x05.
  - FIFO holds 0x01..0x04.
  - One `ovf` pulse on the fifth byte.
  - Draining yields 0x01, 0x02, 0x03, 0x04.
- Full with simultaneous pop: with the FIFO full, assert `dout_rdy` on the push cycle of 0x05.
  - No `ovf`.
  - Drain yields 0x02..0x05.
- Reset mid-frame: assert `rst` during bit 4 of 0xFF, release, then send 0x5A.
  - Only 0x5A is received.
  - All outputs are 0 during reset.
- With `UART_RX_PARITY_EN`: send 0x07 with the parity bit set to 1.
  - The byte is accepted.
  - The same byte with the parity bit at 0 gives `frame_err`.
